eda_img_frame_ctrl: RTL and testbench

Frame controller that drives the image RAM's write port and center-address port. It accepts a raster pixel stream over a valid/ready handshake and writes each pixel to its `{i, j}` address. Once the full M×N frame is stored, it sweeps every center address in raster order over a second valid/ready handshake toward the window consumer (regional-max datapath). It sits between the pixel source and the image RAM and sequences load-then-scan for one frame per `start`.

---
 rtl/eda_img_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_eda_img_frame_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/eda_img_frame_ctrl.sv
// Frame controller: loads one raster frame into the image RAM, then sweeps
// every center address in raster order toward the window consumer.

`ifndef CFG_M
`define CFG_M 3
`endif
`ifndef CFG_N
`define CFG_N 5
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 3
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 5
`endif

module eda_img_frame_ctrl #(
  parameter int M           = `CFG_M,
  parameter int N           = `CFG_N,
  parameter int PIXEL_WIDTH = `CFG_PIXEL_WIDTH,
  parameter int ADDR_WIDTH  = `CFG_ADDR_WIDTH,
  parameter int I_WIDTH     = `CFG_I_WIDTH,
  parameter int J_WIDTH     = `CFG_J_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   pixel_ready,
  output logic                   write_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic [ADDR_WIDTH-1:0]  center_addr,
  output logic                   center_valid,
  input  logic                   center_ready,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

  state_t                 state_q, state_d;
  logic [I_WIDTH-1:0]     wi_q, wi_d, ci_q, ci_d;
  logic [J_WIDTH-1:0]     wj_q, wj_d, cj_q, cj_d;
  logic                   pixel_ready_q, center_valid_q, busy_q, frame_done_q;
  logic                   write_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [PIXEL_WIDTH-1:0] pixel_out_q;
  logic                   pix_hs_s, ctr_hs_s;

  // handshakes qualify on the registered ready/valid, so they never depend combinationally on each other
  assign pix_hs_s = pixel_ready_q & pixel_valid;
  assign ctr_hs_s = center_valid_q & center_ready;

  // next-state and raster counter advance
  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    wj_d    = wj_q;
    ci_d    = ci_q;
    cj_d    = cj_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          wi_d    = {I_WIDTH{1'b0}};
          wj_d    = {J_WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (pix_hs_s) begin
          if (wj_q == J_LAST) begin
            wj_d = {J_WIDTH{1'b0}};
            if (wi_q == I_LAST) begin
              wi_d    = {I_WIDTH{1'b0}};
              state_d = S_FLUSH;
            end else begin
              wi_d = wi_q + I_WIDTH'(1);
            end
          end else begin
            wj_d = wj_q + J_WIDTH'(1);
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        ci_d    = {I_WIDTH{1'b0}};
        cj_d    = {J_WIDTH{1'b0}};
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (ctr_hs_s) begin
          if (cj_q == J_LAST) begin
            cj_d = {J_WIDTH{1'b0}};
            if (ci_q == I_LAST) begin
              ci_d    = {I_WIDTH{1'b0}};
              state_d = S_DONE;
            end else begin
              ci_d = ci_q + I_WIDTH'(1);
            end
          end else begin
            cj_d = cj_q + J_WIDTH'(1);
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state, counters and registered outputs; status flags are decoded from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      wi_q           <= {I_WIDTH{1'b0}};
      wj_q           <= {J_WIDTH{1'b0}};
      ci_q           <= {I_WIDTH{1'b0}};
      cj_q           <= {J_WIDTH{1'b0}};
      pixel_ready_q  <= 1'b0;
      center_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      write_en_q     <= 1'b0;
      wr_addr_q      <= {ADDR_WIDTH{1'b0}};
      pixel_out_q    <= {PIXEL_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      wi_q           <= wi_d;
      wj_q           <= wj_d;
      ci_q           <= ci_d;
      cj_q           <= cj_d;
      pixel_ready_q  <= (state_d == S_LOAD);
      center_valid_q <= (state_d == S_SCAN);
      busy_q         <= (state_d != S_IDLE);
      frame_done_q   <= (state_d == S_DONE);
      write_en_q     <= pix_hs_s;
      if (pix_hs_s) begin
        wr_addr_q   <= ADDR_WIDTH'({wi_q, wj_q});
        pixel_out_q <= pixel_in;
      end else begin
        wr_addr_q   <= wr_addr_q;
        pixel_out_q <= pixel_out_q;
      end
    end
  end

  assign pixel_ready  = pixel_ready_q;
  assign center_valid = center_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign write_en     = write_en_q;
  assign wr_addr      = wr_addr_q;
  assign pixel_out    = pixel_out_q;
  assign center_addr  = ADDR_WIDTH'({ci_q, cj_q});

endmodule

// File: tb/tb_eda_img_frame_ctrl.sv
// Directed bench for eda_img_frame_ctrl with M=3, N=5, J_WIDTH=3:
// a vector table for reset/start/first writes, then whole-frame sequences.

module tb_eda_img_frame_ctrl;

  localparam int M  = 3;
  localparam int N  = 5;
  localparam int PW = 8;
  localparam int AW = 5;
  localparam int IW = 2;
  localparam int JW = 3;
  localparam int FRAME = M * N;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          pixel_valid;
  logic [PW-1:0] pixel_in;
  logic          pixel_ready;
  logic          write_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] pixel_out;
  logic [AW-1:0] center_addr;
  logic          center_valid;
  logic          center_ready;
  logic          busy;
  logic          frame_done;

  int tests;
  int failed;

  eda_img_frame_ctrl #(
    .M(M), .N(N), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .I_WIDTH(IW), .J_WIDTH(JW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .pixel_valid(pixel_valid), .pixel_in(pixel_in), .pixel_ready(pixel_ready),
    .write_en(write_en), .wr_addr(wr_addr), .pixel_out(pixel_out),
    .center_addr(center_addr), .center_valid(center_valid), .center_ready(center_ready),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected outputs packed as {pr, we, wa[4:0], po[7:0], cv, ca[4:0], busy, fd}
  typedef struct {
    logic        rn;
    logic        st;
    logic        pv;
    logic [7:0]  pin;
    logic        cr;
    logic [22:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic st, input logic pv, input logic [7:0] pin,
                              input logic pr, input logic we, input logic [4:0] wa, input logic [7:0] po,
                              input logic bz);
    vec_t v;
    v.rn  = rn;
    v.st  = st;
    v.pv  = pv;
    v.pin = pin;
    v.cr  = 1'b0;
    v.exp = {pr, we, wa, po, 1'b0, 5'd0, bz, 1'b0};
    return v;
  endfunction

  function automatic logic [22:0] outs();
    return {pixel_ready, write_en, wr_addr, pixel_out, center_valid, center_addr, busy, frame_done};
  endfunction

  function automatic logic [4:0] exp_addr(input int idx);
    return 5'(((idx / N) << JW) + (idx % N));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame starting at a negedge in IDLE; optionally resets mid-frame.
  task automatic run_frame(input bit bubbled, input int stall_len, input bit poke,
                           input int rst_pix, input int rst_ctr);
    int cyc, n_sent, n_ctr, last_pix_cyc, first_wr, last_wr, cnt10, stall_left;
    bit prev_pix_hs, prev_last_ctr, prev_cv, prev_cr, done_seen, pix_hs, ctr_hs, timed_out;
    logic [4:0]  prev_ca, last_wa;
    logic [7:0]  last_po;
    logic [12:0] wr_q[$];
    logic [4:0]  c_q[$];
    n_sent = 0; n_ctr = 0; last_pix_cyc = -10; first_wr = -1; last_wr = -1; cnt10 = 0;
    stall_left = stall_len; prev_pix_hs = 0; prev_last_ctr = 0; prev_cv = 0; prev_cr = 0;
    done_seen = 0; timed_out = 1; prev_ca = 5'd0;
    last_wa = wr_addr; last_po = pixel_out;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      chk("we_latency", write_en, prev_pix_hs);
      if (write_en) begin
        wr_q.push_back({wr_addr, pixel_out});
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end else begin
        chk("wr_hold", {wr_addr, pixel_out}, {last_wa, last_po});
      end
      last_wa = wr_addr;
      last_po = pixel_out;
      if (cyc == 1) begin
        chk("start_busy", busy, 1);
        chk("start_ready", pixel_ready, 1);
      end
      if (cyc == last_pix_cyc + 1) begin
        chk("flush_ready", pixel_ready, 0);
        chk("flush_cv", center_valid, 0);
      end
      if (cyc == last_pix_cyc + 2) chk("scan_start", center_valid, 1);
      if (prev_cv && !prev_cr) chk("ca_stable", center_addr, prev_ca);
      chk("frame_done", frame_done, prev_last_ctr);
      if (done_seen) begin
        chk("idle_after_done", busy, 0);
        timed_out = 0;
        break;
      end
      if (frame_done) done_seen = 1;

      if ((rst_pix >= 0 && pixel_ready && n_sent == rst_pix) ||
          (rst_ctr >= 0 && center_valid && n_ctr == rst_ctr)) begin
        reset_n = 1'b0; pixel_valid = 1'b1; center_ready = 1'b1; start = 1'b0;
        pixel_in = 8'(n_sent);
        @(posedge clk);
        #1;
        chk("mid_reset", outs(), 23'h0);
        reset_n = 1'b1; pixel_valid = 1'b0; center_ready = 1'b0;
        @(negedge clk);
        return;
      end

      start       = (cyc == 0) || (poke && (cyc % 4 == 2)) || (poke && frame_done);
      pixel_valid = (n_sent < FRAME) && (!bubbled || (cyc % 2 == 1));
      pixel_in    = 8'(n_sent);
      center_ready = 1'b1;
      if (center_valid && center_addr == 5'd10 && stall_left > 0) begin
        center_ready = 1'b0;
        stall_left--;
      end
      pix_hs = pixel_valid && pixel_ready;
      ctr_hs = center_valid && center_ready;
      if (pix_hs) begin
        n_sent++;
        if (n_sent == FRAME) last_pix_cyc = cyc;
      end
      if (center_valid && center_addr == 5'd10) cnt10++;
      if (ctr_hs) begin
        c_q.push_back(center_addr);
        n_ctr++;
      end
      prev_pix_hs   = pix_hs;
      prev_last_ctr = ctr_hs && (n_ctr == FRAME);
      prev_cv       = center_valid;
      prev_cr       = center_ready;
      prev_ca       = center_addr;
    end
    start = 1'b0; pixel_valid = 1'b0; center_ready = 1'b0;
    chk("timeout", timed_out, 0);
    chk("n_writes", wr_q.size(), FRAME);
    for (int i = 0; i < wr_q.size() && i < FRAME; i++) begin
      chk("wr_addr_seq", wr_q[i][12:8], exp_addr(i));
      chk("wr_data_seq", wr_q[i][7:0], i);
    end
    chk("n_centers", c_q.size(), FRAME);
    for (int i = 0; i < c_q.size() && i < FRAME; i++) chk("center_seq", c_q[i], exp_addr(i));
    if (!bubbled) chk("wr_burst", last_wr - first_wr, FRAME - 1);
    chk("stall_cycles", cnt10, stall_len + 1);
  endtask

  vec_t tbl[13];

  initial begin
    tests = 0; failed = 0;
    reset_n = 1'b0; start = 1'b0; pixel_valid = 1'b0; pixel_in = 8'h00; center_ready = 1'b0;

    //            rn    st    pv    pin    pr    we    wa     po     busy
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 5'd0, 8'h11, 1'b1);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 5'd0, 8'h11, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 5'd1, 8'h22, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 5'd2, 8'h33, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 5'd0, 8'h55, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 5'd1, 8'h66, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reset_n      = tbl[i].rn;
      start        = tbl[i].st;
      pixel_valid  = tbl[i].pv;
      pixel_in     = tbl[i].pin;
      center_ready = tbl[i].cr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    @(negedge clk);
    start = 1'b0; pixel_valid = 1'b0;
    run_frame(1'b0, 0, 1'b0, -1, -1);  // full rate, no stall
    run_frame(1'b1, 3, 1'b1, -1, -1);  // bubbled, stall at (1,2), start pokes incl. DONE
    run_frame(1'b0, 0, 1'b0, -1, -1);  // start in the IDLE cycle right after DONE
    run_frame(1'b0, 0, 1'b0, 7, -1);   // reset at pixel 7
    run_frame(1'b0, 0, 1'b1, -1, -1);  // reloads from address 0
    run_frame(1'b0, 0, 1'b0, -1, 6);   // reset at center 6
    run_frame(1'b1, 0, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
